// File: rtl/operand_latch_stage_pkg.sv
// Shared definitions for the ID/EX operand latch stage: default widths,
// forward-select codes and the load-use FSM encoding.
package operand_latch_stage_pkg;

    localparam int unsigned DATA_WIDTH_DEF        = 16;
    localparam int unsigned REG_NUM_WIDTH_DEF     = 4;
    localparam int unsigned REG_FORWARD_WIDTH_DEF = 2;
    localparam int unsigned OPCODE_WIDTH_DEF      = 4;
    localparam int unsigned STALL_CNT_WIDTH       = 16;

    // Operand source selects produced by register_forward (2'b11 reserved)
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_R0  = 2'b10;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LU_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Operand source mux: register file / EX result / r0 write port, with a
// load-data override used in the cycle after a load-use bubble.
// Ports:
//   sel         forward select (00 reg, 01 ex, 10 r0, 11 treated as reg)
//   lu_override take load_data regardless of sel
//   reg_data, ex_result, r0_result, load_data  candidate operands
//   data_c      selected operand (combinational)
module operand_fwd_mux
    import operand_latch_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [1:0]            sel,
    input  logic                  lu_override,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic [DATA_WIDTH-1:0] r0_result,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] data_c
);

    always_comb begin
        data_c = reg_data;
        if (lu_override) begin
            data_c = load_data;
        end else begin
            case (sel)
                FWD_EX:  data_c = ex_result;
                FWD_R0:  data_c = r0_result;
                default: data_c = reg_data;
            endcase
        end
    end

endmodule

// File: rtl/operand_latch_stage.sv
// ID/EX pipeline register. Muxes both operands, latches them with the
// decoded control for EX, and inserts one bubble on a load-use hazard before
// supplying the loaded data to the dependent operand.
// Optional macro LOAD_USE_STALL_CNT_EN adds stall_count / stall_count_clr.
// Ports:
//   clk, rst                          clock, async active-high reset
//   id_*                              decoded ID-stage instruction
//   reg_forward_1/2                   operand source selects
//   ex_result, r0_result              forwarded values
//   mem_load_data                     MEM-stage load data
//   stall_in, flush                   downstream hold, branch squash
//   ex_* , rn1_ex, write_reg, write_r0  registered EX-stage state
//   id_stall                          combinational freeze of PC and IF/ID
module operand_latch_stage
    import operand_latch_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = DATA_WIDTH_DEF,
    parameter int unsigned REG_NUM_WIDTH     = REG_NUM_WIDTH_DEF,
    parameter int unsigned REG_FORWARD_WIDTH = REG_FORWARD_WIDTH_DEF,
    parameter int unsigned OPCODE_WIDTH      = OPCODE_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_NUM_WIDTH-1:0]     id_rn_1,
    input  logic [REG_NUM_WIDTH-1:0]     id_rn_2,
    input  logic [DATA_WIDTH-1:0]        id_data_1,
    input  logic [DATA_WIDTH-1:0]        id_data_2,
    input  logic [OPCODE_WIDTH-1:0]      id_opcode,
    input  logic                         id_write_reg,
    input  logic                         id_write_r0,
    input  logic                         id_mem_read,
    input  logic [REG_FORWARD_WIDTH-1:0] reg_forward_1,
    input  logic [REG_FORWARD_WIDTH-1:0] reg_forward_2,
    input  logic [DATA_WIDTH-1:0]        ex_result,
    input  logic [DATA_WIDTH-1:0]        r0_result,
    input  logic [DATA_WIDTH-1:0]        mem_load_data,
    input  logic                         stall_in,
    input  logic                         flush,
`ifdef LOAD_USE_STALL_CNT_EN
    input  logic                         stall_count_clr,
    output logic [STALL_CNT_WIDTH-1:0]   stall_count,
`endif
    output logic                         ex_valid,
    output logic [DATA_WIDTH-1:0]        ex_op_1,
    output logic [DATA_WIDTH-1:0]        ex_op_2,
    output logic [OPCODE_WIDTH-1:0]      ex_opcode,
    output logic [REG_NUM_WIDTH-1:0]     rn1_ex,
    output logic                         write_reg,
    output logic                         write_r0,
    output logic                         ex_mem_read,
    output logic                         id_stall
);

    state_t                    state_q, state_d;
    logic [REG_NUM_WIDTH-1:0]  lu_rn_q, lu_rn_d;
    logic                      hazard;
    logic                      lu_ovr_1, lu_ovr_2;
    logic [DATA_WIDTH-1:0]     op_1_c, op_2_c;

    logic                      ex_valid_d, write_reg_d, write_r0_d, ex_mem_read_d;
    logic [DATA_WIDTH-1:0]     ex_op_1_d, ex_op_2_d;
    logic [OPCODE_WIDTH-1:0]   ex_opcode_d;
    logic [REG_NUM_WIDTH-1:0]  rn1_ex_d;

    // EX holds a load whose destination is read by the instruction in ID
    assign hazard = id_valid & ex_valid & ex_mem_read & write_reg &
                    ((id_rn_1 == rn1_ex) | (id_rn_2 == rn1_ex));

    // After the bubble, the dependent operand(s) take the load data directly
    assign lu_ovr_1 = (state_q == ST_LU_WAIT) & (id_rn_1 == lu_rn_q);
    assign lu_ovr_2 = (state_q == ST_LU_WAIT) & (id_rn_2 == lu_rn_q);

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux_1 (
        .sel         (2'(reg_forward_1)),
        .lu_override (lu_ovr_1),
        .reg_data    (id_data_1),
        .ex_result   (ex_result),
        .r0_result   (r0_result),
        .load_data   (mem_load_data),
        .data_c      (op_1_c)
    );

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux_2 (
        .sel         (2'(reg_forward_2)),
        .lu_override (lu_ovr_2),
        .reg_data    (id_data_2),
        .ex_result   (ex_result),
        .r0_result   (r0_result),
        .load_data   (mem_load_data),
        .data_c      (op_2_c)
    );

    // Next-state and next-register values; default is hold
    always_comb begin
        state_d       = state_q;
        lu_rn_d       = lu_rn_q;
        ex_valid_d    = ex_valid;
        ex_op_1_d     = ex_op_1;
        ex_op_2_d     = ex_op_2;
        ex_opcode_d   = ex_opcode;
        rn1_ex_d      = rn1_ex;
        write_reg_d   = write_reg;
        write_r0_d    = write_r0;
        ex_mem_read_d = ex_mem_read;
        id_stall      = 1'b0;

        if (state_q == ST_RUN) begin
            id_stall = hazard;
        end

        if (flush) begin
            ex_valid_d    = 1'b0;
            ex_op_1_d     = '0;
            ex_op_2_d     = '0;
            ex_opcode_d   = '0;
            rn1_ex_d      = '0;
            write_reg_d   = 1'b0;
            write_r0_d    = 1'b0;
            ex_mem_read_d = 1'b0;
            state_d       = ST_RUN;
        end else if (stall_in) begin
            state_d = state_q;
        end else if ((state_q == ST_RUN) && hazard) begin
            ex_valid_d    = 1'b0;
            ex_op_1_d     = '0;
            ex_op_2_d     = '0;
            ex_opcode_d   = '0;
            rn1_ex_d      = '0;
            write_reg_d   = 1'b0;
            write_r0_d    = 1'b0;
            ex_mem_read_d = 1'b0;
            lu_rn_d       = rn1_ex;
            state_d       = ST_LU_WAIT;
        end else begin
            ex_valid_d    = id_valid;
            ex_op_1_d     = op_1_c;
            ex_op_2_d     = op_2_c;
            ex_opcode_d   = id_opcode;
            rn1_ex_d      = id_rn_1;
            write_reg_d   = id_valid & id_write_reg;
            write_r0_d    = id_valid & id_write_r0;
            ex_mem_read_d = id_valid & id_mem_read;
            state_d       = ST_RUN;
        end
    end

    // Pipeline and FSM registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            lu_rn_q     <= '0;
            ex_valid    <= 1'b0;
            ex_op_1     <= '0;
            ex_op_2     <= '0;
            ex_opcode   <= '0;
            rn1_ex      <= '0;
            write_reg   <= 1'b0;
            write_r0    <= 1'b0;
            ex_mem_read <= 1'b0;
        end else begin
            state_q     <= state_d;
            lu_rn_q     <= lu_rn_d;
            ex_valid    <= ex_valid_d;
            ex_op_1     <= ex_op_1_d;
            ex_op_2     <= ex_op_2_d;
            ex_opcode   <= ex_opcode_d;
            rn1_ex      <= rn1_ex_d;
            write_reg   <= write_reg_d;
            write_r0    <= write_r0_d;
            ex_mem_read <= ex_mem_read_d;
        end
    end

`ifdef LOAD_USE_STALL_CNT_EN
    logic enter_lu;

    assign enter_lu = !flush && !stall_in && (state_q == ST_RUN) && hazard;

    // Saturating count of load-use bubbles; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_count_clr) begin
            stall_count <= '0;
        end else if (enter_lu && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_WIDTH'(1);
        end
    end
`endif

endmodule
